// File: rtl/rtype_sequencer_if.sv
// Control bundle between the R-type sequencer and the single-bus datapath.
// The sequencer sits on the master side; the datapath (or a bench) on the slave side.
interface rtype_sequencer_if #(
    parameter int ADDR_W = 4
);
    localparam int NREG = 1 << ADDR_W;

    logic            start;
    logic [31:0]     ir;
    logic            mem_ack;

    logic [NREG-1:0] r_in;
    logic [NREG-1:0] r_out;
    logic            PCout;
    logic            incPC;
    logic            MARin;
    logic            read;
    logic            MDRin;
    logic            PCin;
    logic            IRin;
    logic            MDRout;
    logic            Yin;
    logic            Zin;
    logic            ZLowOut;
    logic            ZHighOut;
    logic            LOin;
    logic            HIin;
    logic [4:0]      opcode;
    logic            busy;
    logic            done;
    logic            illegal;

    modport master (
        input  start, ir, mem_ack,
        output r_in, r_out, PCout, incPC, MARin, read, MDRin, PCin, IRin, MDRout,
               Yin, Zin, ZLowOut, ZHighOut, LOin, HIin, opcode, busy, done, illegal
    );

    modport slave (
        output start, ir, mem_ack,
        input  r_in, r_out, PCout, incPC, MARin, read, MDRin, PCin, IRin, MDRout,
               Yin, Zin, ZLowOut, ZHighOut, LOin, HIin, opcode, busy, done, illegal
    );
endinterface

// File: rtl/rtype_sequencer.sv
// Hardwired Moore control unit: fetch (T0-T2) and execute (T3-T6) of one
// three-register ALU instruction per start pulse.
module rtype_sequencer #(
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              clear,
    rtype_sequencer_if.master ctl
);
    localparam int NREG = 1 << ADDR_W;
    localparam int RA_HI = 26;
    localparam int RB_HI = RA_HI - ADDR_W;
    localparam int RC_HI = RB_HI - ADDR_W;
    localparam int LOW_HI = RC_HI - ADDR_W;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_t;

    state_t state_q, state_d;

    logic [4:0]        op;
    logic [ADDR_W-1:0] ra, rb, rc;
    logic              is_bin, is_un, is_md, legal;
    logic              unused_ir_low;

    assign op = ctl.ir[31:27];
    assign ra = ctl.ir[RA_HI -: ADDR_W];
    assign rb = ctl.ir[RB_HI -: ADDR_W];
    assign rc = ctl.ir[RC_HI -: ADDR_W];
    assign unused_ir_low = ^ctl.ir[LOW_HI:0];
    assign legal = is_bin | is_un;

    always_comb begin
        is_bin = 1'b0;
        is_un  = 1'b0;
        is_md  = 1'b0;
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010:   is_bin = 1'b1;
            5'b01110, 5'b01111: begin
                is_bin = 1'b1;
                is_md  = 1'b1;
            end
            5'b10000, 5'b10001:             is_un = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // T1W is the memory-wait copy of T1; it exists so PCin fires only once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (ctl.start) state_d = S_T0;
            S_T0:        state_d = S_T1;
            S_T1, S_T1W: state_d = ctl.mem_ack ? S_T2 : S_T1W;
            S_T2:        state_d = S_T3;
            S_T3:        state_d = legal ? S_T4 : S_IDLE;
            S_T4:        state_d = S_T5;
            S_T5:        state_d = is_md ? S_T6 : S_IDLE;
            S_T6:        state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ctl.r_in     = '0;
        ctl.r_out    = '0;
        ctl.PCout    = 1'b0;
        ctl.incPC    = 1'b0;
        ctl.MARin    = 1'b0;
        ctl.read     = 1'b0;
        ctl.MDRin    = 1'b0;
        ctl.PCin     = 1'b0;
        ctl.IRin     = 1'b0;
        ctl.MDRout   = 1'b0;
        ctl.Yin      = 1'b0;
        ctl.Zin      = 1'b0;
        ctl.ZLowOut  = 1'b0;
        ctl.ZHighOut = 1'b0;
        ctl.LOin     = 1'b0;
        ctl.HIin     = 1'b0;
        ctl.opcode   = '0;
        ctl.busy     = (state_q != S_IDLE);
        ctl.done     = 1'b0;
        ctl.illegal  = 1'b0;
        case (state_q)
            S_T0: begin
                ctl.PCout = 1'b1;
                ctl.MARin = 1'b1;
                ctl.incPC = 1'b1;
                ctl.Zin   = 1'b1;
            end
            S_T1, S_T1W: begin
                ctl.read    = 1'b1;
                ctl.MDRin   = 1'b1;
                ctl.ZLowOut = 1'b1;
                ctl.PCin    = (state_q == S_T1);
            end
            S_T2: begin
                ctl.MDRout = 1'b1;
                ctl.IRin   = 1'b1;
            end
            S_T3: begin
                ctl.opcode = op;
                if (legal) begin
                    ctl.r_out[rb] = 1'b1;
                    ctl.Yin       = 1'b1;
                end else begin
                    ctl.illegal = 1'b1;
                end
            end
            S_T4: begin
                ctl.opcode = op;
                ctl.Zin    = 1'b1;
                if (is_un) ctl.r_out[rb] = 1'b1;
                else       ctl.r_out[rc] = 1'b1;
            end
            S_T5: begin
                ctl.opcode  = op;
                ctl.ZLowOut = 1'b1;
                if (is_md) begin
                    ctl.LOin = 1'b1;
                end else begin
                    ctl.r_in[ra] = 1'b1;
                    ctl.done     = 1'b1;
                end
            end
            S_T6: begin
                ctl.opcode   = op;
                ctl.ZHighOut = 1'b1;
                ctl.HIin     = 1'b1;
                ctl.done     = 1'b1;
            end
            default: ;
        endcase
    end

    initial begin : unused_width_guard
    end
endmodule
